demux_rr_dispatcher: RTL

- Sequences a single valid/ready input stream onto eight output lanes through a registered 1-to-8 demultiplexer.
- Lane selection is either round-robin with a configurable burst length and a lane-enable mask, or directed by a per-beat destination field.
- Sits between a single producer and eight consumer channels; it owns the demux select and holds each beat until the chosen lane accepts it.

---
 rtl/demux_pkg.sv | 8 +
 rtl/rr_next_lane.sv | 25 ++
 rtl/demux_rr_dispatcher.sv | 97 +++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared types and sizing for the round-robin / directed 1-to-8 beat dispatcher.
package demux_pkg;
    localparam int NUM_LANES = 8;
    localparam int LANE_W    = 3;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;
    typedef enum logic {RR = 1'b0, DIR = 1'b1} mode_e;
endpackage

// File: rtl/rr_next_lane.sv
// Finds the first enabled lane at or above start_ptr_i, wrapping modulo NUM_LANES.
module rr_next_lane
    import demux_pkg::*;
(
    input  logic [LANE_W-1:0]    start_ptr_i,
    input  logic [NUM_LANES-1:0] lane_en_i,
    output logic [LANE_W-1:0]    lane_o,
    output logic                 found_o
);
    logic [LANE_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest enabled lane wins.
    always_comb begin
        lane_o  = start_ptr_i;
        found_o = 1'b0;
        idx     = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            idx = start_ptr_i + LANE_W'(i);
            if (lane_en_i[idx]) begin
                lane_o  = idx;
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/demux_rr_dispatcher.sv
// Registered 1-to-8 demux: holds one beat and steers it by round-robin bursts or by in_dest.
module demux_rr_dispatcher
    import demux_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [LANE_W-1:0]    in_dest,
    output logic                 in_ready,
    input  logic                 mode,
    input  logic [NUM_LANES-1:0] lane_en,
    output logic [NUM_LANES-1:0] out_valid,
    output logic [DATA_W-1:0]    out_data,
    input  logic [NUM_LANES-1:0] out_ready,
    output logic [LANE_W-1:0]    sel,
    output logic                 busy
);
    localparam int CNT_W = 9;

    state_e                state_q;
    logic [NUM_LANES-1:0]  out_valid_q;
    logic [DATA_W-1:0]     out_data_q;
    logic [LANE_W-1:0]     sel_q;
    logic [LANE_W-1:0]     rr_ptr_q;
    logic [CNT_W-1:0]      burst_cnt_q;

    logic [LANE_W-1:0]     tgt_lane, nxt_lane, nxt_start, sel_d;
    logic                  tgt_found, nxt_found;
    logic [CNT_W-1:0]      cnt_eff, count;
    logic                  burst_done, directed, lane_available, fire, accept;

    rr_next_lane u_tgt (
        .start_ptr_i (rr_ptr_q),
        .lane_en_i   (lane_en),
        .lane_o      (tgt_lane),
        .found_o     (tgt_found)
    );

    assign nxt_start = tgt_lane + LANE_W'(1);

    rr_next_lane u_nxt (
        .start_ptr_i (nxt_start),
        .lane_en_i   (lane_en),
        .lane_o      (nxt_lane),
        .found_o     (nxt_found)
    );

    assign directed       = (mode_e'(mode) == DIR);
    assign lane_available = directed | tgt_found;
    assign fire           = (state_q == HOLD) & out_ready[sel_q];
    // in_ready never looks at in_valid, so the producer sees no combinational loop.
    assign in_ready       = ((state_q == IDLE) | fire) & lane_available;
    assign accept         = in_valid & in_ready;

    // A pointer that landed on a lane since disabled starts a fresh burst.
    assign cnt_eff    = lane_en[rr_ptr_q] ? burst_cnt_q : '0;
    assign count      = cnt_eff + CNT_W'(1);
    assign burst_done = (count == CNT_W'(BURST_LEN));
    assign sel_d      = directed ? in_dest : tgt_lane;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= '0;
            out_data_q  <= '0;
            sel_q       <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else if (accept) begin
            state_q     <= HOLD;
            out_data_q  <= in_data;
            sel_q       <= sel_d;
            out_valid_q <= NUM_LANES'(1) << sel_d;
            if (!directed) begin
                if (burst_done) begin
                    burst_cnt_q <= '0;
                    rr_ptr_q    <= nxt_found ? nxt_lane : tgt_lane;
                end else begin
                    burst_cnt_q <= count;
                    rr_ptr_q    <= tgt_lane;
                end
            end
        end else if (fire) begin
            state_q     <= IDLE;
            out_valid_q <= '0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sel       = sel_q;
    assign busy      = (state_q == HOLD);
endmodule
